// File: rtl/div_pkg.sv
// Shared constants, state encoding and sign helper for the AXIS integer divider.
package div_pkg;

  localparam int DIV_W       = 32;
  localparam int DOUT_W      = 64;
  localparam int DIV_LATENCY = 34;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic en);
    if (en) begin
      neg_if = ~v + 32'd1;
    end else begin
      neg_if = v;
    end
  endfunction

endpackage

// File: rtl/div_unsigned_core.sv
// Iterative restoring radix-2 magnitude divider: one quotient bit per cycle, 32 steps after start.
module div_unsigned_core
  import div_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [DIV_W-1:0] quotient_o,
  output logic [DIV_W-1:0] remainder_o
);

  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic             busy_q, busy_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [DIV_W:0]   rem_sh_s;
  logic [DIV_W-1:0] diff_s;
  logic             fits_s;

  // The shifted partial remainder can reach 33 bits; when it fits, the difference is below 2^32.
  always_comb begin
    rem_sh_s = {rem_q, quo_q[DIV_W-1]};
    fits_s   = (rem_sh_s >= {1'b0, dvs_q});
    diff_s   = rem_sh_s[DIV_W-1:0] - dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = 32'd0;
      dvs_d  = divisor_i;
      busy_d = 1'b1;
      cnt_d  = 5'd0;
    end else if (busy_q) begin
      quo_d = {quo_q[DIV_W-2:0], fits_s};
      rem_d = fits_s ? diff_s : rem_sh_s[DIV_W-1:0];
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q  <= 32'd0;
      rem_q  <= 32'd0;
      dvs_q  <= 32'd0;
      busy_q <= 1'b0;
      cnt_q  <= 5'd0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/axis_int_divider.sv
// AXIS wrapper: operand handshake, magnitude/sign handling and fixed-latency result strobe.
module axis_int_divider
  import div_pkg::*;
#(
  parameter bit SIGNED  = 1'b1,
  parameter int LATENCY = DIV_LATENCY
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_axis_divisor_tvalid,
  output logic              s_axis_divisor_tready,
  input  logic [DIV_W-1:0]  s_axis_divisor_tdata,
  input  logic              s_axis_dividend_tvalid,
  output logic              s_axis_dividend_tready,
  input  logic [DIV_W-1:0]  s_axis_dividend_tdata,
  output logic              m_axis_dout_tvalid,
  output logic [DOUT_W-1:0] m_axis_dout_tdata
);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              tvalid_q, tvalid_d;
  logic [DOUT_W-1:0] tdata_q, tdata_d;
  logic              ready_s, accept_s, a_neg_s, b_neg_s;
  logic [DIV_W-1:0]  mag_a_s, mag_b_s, quo_s, rem_s;

  assign ready_s  = (state_q == IDLE) && !areset;
  assign accept_s = ready_s && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
  assign a_neg_s  = SIGNED && s_axis_dividend_tdata[DIV_W-1];
  assign b_neg_s  = SIGNED && s_axis_divisor_tdata[DIV_W-1];
  assign mag_a_s  = neg_if(s_axis_dividend_tdata, a_neg_s);
  assign mag_b_s  = neg_if(s_axis_divisor_tdata, b_neg_s);

  div_unsigned_core u_core (
    .clk_i       (aclk),
    .rst_i       (areset),
    .start_i     (accept_s),
    .dividend_i  (mag_a_s),
    .divisor_i   (mag_b_s),
    .quotient_o  (quo_s),
    .remainder_o (rem_s)
  );

  // cnt_q equals k+1 after edge T+k, so the result fires on edge T+LATENCY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    tvalid_d = 1'b0;
    tdata_d  = tdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = BUSY;
          cnt_d   = 8'd1;
          negq_d  = a_neg_s ^ b_neg_s;
          negr_d  = a_neg_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 8'(LATENCY)) begin
          state_d  = IDLE;
          tvalid_d = 1'b1;
          tdata_d  = {neg_if(quo_s, negq_q), neg_if(rem_s, negr_q)};
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  assign s_axis_divisor_tready  = ready_s;
  assign s_axis_dividend_tready = ready_s;
  assign m_axis_dout_tvalid     = tvalid_q;
  assign m_axis_dout_tdata      = tdata_q;

endmodule

// File: tb/tb_axis_int_divider.sv
// Scoreboard bench: unsigned and signed instances share stimulus; monitors pop expected results.
module tb_axis_int_divider;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        dv_valid = 1'b0, dd_valid = 1'b0;
  logic [31:0] dv_data = 32'd0, dd_data = 32'd0;

  logic        rdy_dv_u, rdy_dd_u, tv_u;
  logic [63:0] td_u;
  logic        rdy_dv_s, rdy_dd_s, tv_s;
  logic [63:0] td_s;
  logic [3:0]  rdy_all;

  assign rdy_all = {rdy_dv_u, rdy_dd_u, rdy_dv_s, rdy_dd_s};

  axis_int_divider #(.SIGNED(1'b0), .LATENCY(34)) dut_u (
    .aclk                   (aclk),
    .areset                 (areset),
    .s_axis_divisor_tvalid  (dv_valid),
    .s_axis_divisor_tready  (rdy_dv_u),
    .s_axis_divisor_tdata   (dv_data),
    .s_axis_dividend_tvalid (dd_valid),
    .s_axis_dividend_tready (rdy_dd_u),
    .s_axis_dividend_tdata  (dd_data),
    .m_axis_dout_tvalid     (tv_u),
    .m_axis_dout_tdata      (td_u)
  );

  axis_int_divider #(.SIGNED(1'b1), .LATENCY(34)) dut_s (
    .aclk                   (aclk),
    .areset                 (areset),
    .s_axis_divisor_tvalid  (dv_valid),
    .s_axis_divisor_tready  (rdy_dv_s),
    .s_axis_divisor_tdata   (dv_data),
    .s_axis_dividend_tvalid (dd_valid),
    .s_axis_dividend_tready (rdy_dd_s),
    .s_axis_dividend_tdata  (dd_data),
    .m_axis_dout_tvalid     (tv_s),
    .m_axis_dout_tdata      (td_s)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];

  // Reference: plain integer arithmetic plus the documented divide-by-zero results.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, qq, rr;
    logic [31:0] q32, r32;
    if (!sgn) begin
      if (b == 32'd0) begin
        q32 = 32'hFFFF_FFFF;
        r32 = a;
      end else begin
        q32 = a / b;
        r32 = a % b;
      end
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
        q32 = (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        r32 = a;
      end else begin
        qq  = sa / sb;
        rr  = sa % sb;
        q32 = qq[31:0];
        r32 = rr[31:0];
      end
    end
    return {q32, r32};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input bit sgn, input logic [63:0] d);
    exp_t e;
    if ((sgn && q_s.size() == 0) || (!sgn && q_u.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_tvalid signed=%0d: got %h expected no output", sgn, d);
    end else begin
      if (sgn) e = q_s.pop_front();
      else     e = q_u.pop_front();
      check(sgn ? "dout_tdata_s" : "dout_tdata_u", d, e.data);
      check(sgn ? "latency_s" : "latency_u", 64'(cyc), 64'(e.cyc));
    end
  endtask

  always @(negedge aclk) begin
    if (tv_u) mon(1'b0, td_u);
    if (tv_s) mon(1'b1, td_s);
  end

  task automatic wait_idle();
    int w = 0;
    @(negedge aclk);
    while (rdy_all != 4'hF && w < 100) begin
      @(negedge aclk);
      w++;
    end
    if (w >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got tready %b expected 1111", rdy_all);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit expect_out);
    exp_t e;
    int   acc;
    wait_idle();
    dd_data  = a;
    dv_data  = b;
    dd_valid = 1'b1;
    dv_valid = 1'b1;
    @(posedge aclk);
    #1;
    dd_valid = 1'b0;
    dv_valid = 1'b0;
    acc = cyc;
    if (expect_out) begin
      e.cyc  = acc + 34;
      e.data = ref_div(a, b, 1'b0);
      q_u.push_back(e);
      e.data = ref_div(a, b, 1'b1);
      q_s.push_back(e);
    end
    check("tready_busy", {60'd0, rdy_all}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          w;

    repeat (3) @(negedge aclk);
    check("reset_tready", {60'd0, rdy_all}, 64'd0);
    check("reset_tvalid", {62'd0, tv_u, tv_s}, 64'd0);
    check("reset_tdata_u", td_u, 64'd0);
    check("reset_tdata_s", td_s, 64'd0);
    areset = 1'b0;
    #1;
    check("tready_after_reset", {60'd0, rdy_all}, 64'hF);

    issue(32'd100, 32'd7, 1'b1);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'd5, 32'd0, 1'b1);
    issue(32'hFFFF_FFFB, 32'd0, 1'b1);

    // Lone tvalids must not start an operation.
    wait_idle();
    dd_data  = 32'd77;
    dd_valid = 1'b1;
    repeat (5) @(negedge aclk);
    check("lone_dividend_tready", {60'd0, rdy_all}, 64'hF);
    dd_valid = 1'b0;
    dv_data  = 32'd3;
    dv_valid = 1'b1;
    repeat (5) @(negedge aclk);
    check("lone_divisor_tready", {60'd0, rdy_all}, 64'hF);
    dv_valid = 1'b0;

    // Second operand pair while busy is dropped.
    issue(32'd1000, 32'd3, 1'b1);
    repeat (4) @(negedge aclk);
    dd_data  = 32'd9;
    dv_data  = 32'd9;
    dd_valid = 1'b1;
    dv_valid = 1'b1;
    repeat (3) @(negedge aclk);
    dd_valid = 1'b0;
    dv_valid = 1'b0;

    // Reset during the tenth cycle of an operation.
    issue(32'd12345, 32'd67, 1'b0);
    repeat (9) @(negedge aclk);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    check("midreset_tvalid", {62'd0, tv_u, tv_s}, 64'd0);
    check("midreset_tdata_u", td_u, 64'd0);
    check("midreset_tdata_s", td_s, 64'd0);
    areset = 1'b0;
    repeat (45) @(negedge aclk);
    issue(32'd12345, 32'd67, 1'b1);

    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = 32'($urandom_range(1, 20));
        4:       rb = ~32'($urandom_range(0, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
      issue(ra, rb, 1'b1);
    end

    w = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && w < 200) begin
      @(negedge aclk);
      w++;
    end
    if (q_u.size() != 0 || q_s.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q_u.size(), q_s.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
